// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and helpers for the MEM pipeline stage
package mem_pkg;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LD  = 3'b011,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101,
        F3_LWU = 3'b110
    } load_f3_e;

    typedef enum logic [2:0] {
        F3_SB = 3'b000,
        F3_SH = 3'b001,
        F3_SW = 3'b010,
        F3_SD = 3'b011
    } store_f3_e;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_TIMEOUT  = 2'b10,
        FAULT_WIDTH    = 2'b11
    } fault_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_WAIT_GNT  = 2'b01,
        ST_WAIT_RESP = 2'b10
    } state_e;

    // Byte-lane mask for an access size code (funct3[1:0]), before offset shift.
    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/load_extract.sv
// rtl/load_extract.sv - shifts load data by byte offset and sign/zero-extends it
module load_extract
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]             rdata,
    input  logic [$clog2(XLEN/8)-1:0]   offset,
    input  logic [2:0]                  funct3,
    output logic [XLEN-1:0]             ext_data
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] keep;
    logic            msb;

    // Bring the addressed bytes to lane 0, keep the access size, extend the top bit.
    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        keep    = '1;
        msb     = shifted[XLEN-1];
        case (funct3[1:0])
            2'b00: begin keep = XLEN'(8'hFF);         msb = shifted[7];  end
            2'b01: begin keep = XLEN'(16'hFFFF);      msb = shifted[15]; end
            2'b10: begin keep = XLEN'(32'hFFFF_FFFF); msb = shifted[31]; end
            default: ;
        endcase
        ext_data = (shifted & keep) | ((!funct3[2] && msb) ? ~keep : '0);
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage with stalling req/gnt/rvalid data-memory port
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_mem_to_reg,
    input  logic              ex_reg_write,
    input  logic              ex_rd_src,
    input  logic [XLEN-1:0]   ex_pc_to_reg,
    input  logic [XLEN-1:0]   ex_alu_out,
    input  logic [XLEN-1:0]   ex_rs2_data,
    input  logic [4:0]        ex_rd_addr,
    input  logic [2:0]        ex_funct3,
    output logic              mem_stall,
    output logic              dm_req,
    output logic [XLEN/8-1:0] dm_we,
    output logic [XLEN-1:0]   dm_addr,
    output logic [XLEN-1:0]   dm_wdata,
    input  logic              dm_gnt,
    input  logic              dm_rvalid,
    input  logic [XLEN-1:0]   dm_rdata,
    output logic              wb_valid,
    output logic              wb_mem_to_reg,
    output logic              wb_reg_write,
    output logic [XLEN-1:0]   wb_rd_data,
    output logic [XLEN-1:0]   wb_load_data,
    output logic [4:0]        wb_rd_addr,
    output logic [1:0]        wb_fault,
    output logic [XLEN-1:0]   wb_fault_addr
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wb_valid_q, wb_valid_d;
    logic            wb_mem_to_reg_q, wb_mem_to_reg_d;
    logic            wb_reg_write_q, wb_reg_write_d;
    logic [XLEN-1:0] wb_rd_data_q, wb_rd_data_d;
    logic [XLEN-1:0] wb_load_data_q, wb_load_data_d;
    logic [4:0]      wb_rd_addr_q, wb_rd_addr_d;
    fault_e          wb_fault_q, wb_fault_d;
    logic [XLEN-1:0] wb_fault_addr_q, wb_fault_addr_d;

    logic [OW-1:0]   offset;
    logic [3:0]      align_m;
    logic            is_mem, is_store, width_ok, mem_op;
    fault_e          static_fault;
    logic            busy, done, load_done, to_fault, timeout_hit;
    logic [NB-1:0]   we_mask;
    logic [XLEN-1:0] ld_ext;

    assign offset      = ex_alu_out[OW-1:0];
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    load_extract #(.XLEN(XLEN)) u_load_extract (
        .rdata    (dm_rdata),
        .offset   (offset),
        .funct3   (ex_funct3),
        .ext_data (ld_ext)
    );

    // Width/alignment checks; a store wins when both read and write are set.
    always_comb begin
        is_mem   = ex_valid && (ex_mem_read || ex_mem_write);
        is_store = ex_mem_write;
        align_m  = (4'd1 << ex_funct3[1:0]) - 4'd1;
        if (is_store) begin
            width_ok = !ex_funct3[2] && ((ex_funct3[1:0] != 2'b11) || (XLEN == 64));
        end else begin
            case (ex_funct3)
                F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: width_ok = 1'b1;
                F3_LD, F3_LWU:                       width_ok = (XLEN == 64);
                default:                             width_ok = 1'b0;
            endcase
        end
        if (!is_mem)                       static_fault = FAULT_NONE;
        else if (!width_ok)                static_fault = FAULT_WIDTH;
        else if (|(offset & align_m[OW-1:0])) static_fault = FAULT_MISALIGN;
        else                               static_fault = FAULT_NONE;
        mem_op = is_mem && (static_fault == FAULT_NONE);
    end

    // Store lane alignment; outputs follow the EXE/MEM slot, which is frozen while stalled.
    always_comb begin
        we_mask = NB'(size_mask(ex_funct3[1:0]));
        dm_we   = (dm_req && is_store) ? (we_mask << offset) : '0;
        dm_addr = {ex_alu_out[XLEN-1:OW], {OW{1'b0}}};
        for (int i = 0; i < NB; i++) begin
            case (ex_funct3[1:0])
                2'b00:   dm_wdata[8*i +: 8] = ex_rs2_data[7:0];
                2'b01:   dm_wdata[8*i +: 8] = ex_rs2_data[8*(i%2) +: 8];
                2'b10:   dm_wdata[8*i +: 8] = ex_rs2_data[8*(i%4) +: 8];
                default: dm_wdata[8*i +: 8] = ex_rs2_data[8*i +: 8];
            endcase
        end
    end

    // Handshake FSM: issue in IDLE, hold request until grant, then wait for load data.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dm_req    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        load_done = 1'b0;
        to_fault  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    busy   = 1'b1;
                    dm_req = 1'b1;
                    cnt_d  = '0;
                    if (dm_gnt && is_store) done = 1'b1;
                    else if (dm_gnt)        state_d = ST_WAIT_RESP;
                    else                    state_d = ST_WAIT_GNT;
                end
            end
            ST_WAIT_GNT: begin
                busy   = 1'b1;
                dm_req = 1'b1;
                if (dm_gnt && is_store) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end else if (dm_gnt) begin
                    state_d = ST_WAIT_RESP;
                    cnt_d   = '0;
                end else if (timeout_hit) begin
                    done     = 1'b1;
                    to_fault = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WAIT_RESP: begin
                busy = 1'b1;
                if (dm_rvalid) begin
                    done      = 1'b1;
                    load_done = 1'b1;
                    state_d   = ST_IDLE;
                end else if (timeout_hit) begin
                    done     = 1'b1;
                    to_fault = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (rst) dm_req = 1'b0;
        mem_stall = !rst && busy && !done;
    end

    // Next MEM/WB contents; the register simply holds while the stage stalls.
    always_comb begin
        wb_valid_d      = wb_valid_q;
        wb_mem_to_reg_d = wb_mem_to_reg_q;
        wb_reg_write_d  = wb_reg_write_q;
        wb_rd_data_d    = wb_rd_data_q;
        wb_load_data_d  = wb_load_data_q;
        wb_rd_addr_d    = wb_rd_addr_q;
        wb_fault_d      = wb_fault_q;
        wb_fault_addr_d = wb_fault_addr_q;
        if (!mem_stall) begin
            wb_fault_d      = to_fault ? FAULT_TIMEOUT : static_fault;
            wb_valid_d      = ex_valid;
            wb_mem_to_reg_d = ex_mem_to_reg;
            wb_reg_write_d  = ex_reg_write && (wb_fault_d == FAULT_NONE);
            wb_rd_data_d    = ex_rd_src ? ex_pc_to_reg : ex_alu_out;
            wb_rd_addr_d    = ex_rd_addr;
            wb_fault_addr_d = (wb_fault_d != FAULT_NONE) ? ex_alu_out : '0;
            if (load_done) wb_load_data_d = ld_ext;
        end
    end

    // State and MEM/WB registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            wb_valid_q      <= 1'b0;
            wb_mem_to_reg_q <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_rd_data_q    <= '0;
            wb_load_data_q  <= '0;
            wb_rd_addr_q    <= '0;
            wb_fault_q      <= FAULT_NONE;
            wb_fault_addr_q <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            wb_valid_q      <= wb_valid_d;
            wb_mem_to_reg_q <= wb_mem_to_reg_d;
            wb_reg_write_q  <= wb_reg_write_d;
            wb_rd_data_q    <= wb_rd_data_d;
            wb_load_data_q  <= wb_load_data_d;
            wb_rd_addr_q    <= wb_rd_addr_d;
            wb_fault_q      <= wb_fault_d;
            wb_fault_addr_q <= wb_fault_addr_d;
        end
    end

    assign wb_valid      = wb_valid_q;
    assign wb_mem_to_reg = wb_mem_to_reg_q;
    assign wb_reg_write  = wb_reg_write_q;
    assign wb_rd_data    = wb_rd_data_q;
    assign wb_load_data  = wb_load_data_q;
    assign wb_rd_addr    = wb_rd_addr_q;
    assign wb_fault      = wb_fault_q;
    assign wb_fault_addr = wb_fault_addr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_rd_src;
    logic [31:0] ex_pc_to_reg, ex_alu_out, ex_rs2_data;
    logic [4:0]  ex_rd_addr;
    logic [2:0]  ex_funct3;
    logic        mem_stall, dm_req;
    logic [3:0]  dm_we;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        dm_gnt, dm_rvalid;
    logic        wb_valid, wb_mem_to_reg, wb_reg_write;
    logic [31:0] wb_rd_data, wb_load_data, wb_fault_addr;
    logic [4:0]  wb_rd_addr;
    logic [1:0]  wb_fault;

    int checks = 0;
    int failures = 0;

    logic        req0;
    logic [3:0]  we0;
    logic [31:0] addr0, wdata0;
    int          stalls;
    logic        done;

    always #5 clk = ~clk;

    mem_access_stage #(.XLEN(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write), .ex_rd_src(ex_rd_src),
        .ex_pc_to_reg(ex_pc_to_reg), .ex_alu_out(ex_alu_out), .ex_rs2_data(ex_rs2_data),
        .ex_rd_addr(ex_rd_addr), .ex_funct3(ex_funct3),
        .mem_stall(mem_stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .wb_valid(wb_valid), .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write),
        .wb_rd_data(wb_rd_data), .wb_load_data(wb_load_data), .wb_rd_addr(wb_rd_addr),
        .wb_fault(wb_fault), .wb_fault_addr(wb_fault_addr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_ex(input logic v, input logic rd, input logic wr, input logic rw,
                          input logic src, input logic [2:0] f3, input logic [31:0] alu,
                          input logic [31:0] rs2, input logic [31:0] pc, input logic [4:0] rda);
        ex_valid = v; ex_mem_read = rd; ex_mem_write = wr; ex_mem_to_reg = rd;
        ex_reg_write = rw; ex_rd_src = src; ex_funct3 = f3; ex_alu_out = alu;
        ex_rs2_data = rs2; ex_pc_to_reg = pc; ex_rd_addr = rda;
    endtask

    // Called just after a rising edge; gnt_at < 0 means never grant, rv_delay 0 means no rvalid.
    task automatic run_access(input int gnt_at, input int rv_delay, input logic [31:0] rdata);
        logic fin;
        stalls = 0;
        done   = 1'b0;
        fin    = 1'b0;
        for (int k = 0; k < 12 && !fin; k++) begin
            dm_gnt    = (k == gnt_at);
            dm_rvalid = (rv_delay > 0) && (gnt_at >= 0) && (k == gnt_at + rv_delay);
            dm_rdata  = rdata;
            @(negedge clk);
            if (k == 0) begin
                req0 = dm_req; we0 = dm_we; addr0 = dm_addr; wdata0 = dm_wdata;
            end
            if (mem_stall) stalls++;
            else fin = 1'b1;
            @(posedge clk); #1;
        end
        done      = fin;
        dm_gnt    = 1'b0;
        dm_rvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0;
        set_ex(1, 1, 0, 1, 0, 3'b010, 32'h0000_0100, 0, 0, 5'd1);
        @(negedge clk);
        chk("rst_req", {31'b0, dm_req}, 0);
        chk("rst_stall", {31'b0, mem_stall}, 0);
        @(posedge clk); #1;
        chk("rst_wb_valid", {31'b0, wb_valid}, 0);
        chk("rst_wb_rw", {31'b0, wb_reg_write}, 0);
        chk("rst_wb_fault", {30'b0, wb_fault}, 0);
        chk("rst_wb_load", wb_load_data, 0);
        rst = 1'b0;

        // SW 0x104, zero-wait grant
        set_ex(1, 0, 1, 0, 0, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 0, 5'd0);
        run_access(0, 0, 0);
        chk("sw_done", {31'b0, done}, 1);
        chk("sw_req", {31'b0, req0}, 1);
        chk("sw_we", {28'b0, we0}, 4'hF);
        chk("sw_addr", addr0, 32'h0000_0104);
        chk("sw_wdata", wdata0, 32'hDEAD_BEEF);
        chk("sw_stalls", stalls, 0);
        chk("sw_wb_valid", {31'b0, wb_valid}, 1);

        // SB 0x103
        set_ex(1, 0, 1, 0, 0, 3'b000, 32'h0000_0103, 32'h0000_00AB, 0, 5'd0);
        run_access(0, 0, 0);
        chk("sb_we", {28'b0, we0}, 4'h8);
        chk("sb_wdata", wdata0, 32'hABAB_ABAB);
        chk("sb_addr", addr0, 32'h0000_0100);

        // LH 0x102, gnt after 2 cycles, rvalid 1 later
        set_ex(1, 1, 0, 1, 0, 3'b001, 32'h0000_0102, 0, 0, 5'd7);
        run_access(2, 1, 32'h8001_1234);
        chk("lh_stalls", stalls, 3);
        chk("lh_data", wb_load_data, 32'hFFFF_8001);
        chk("lh_rw", {31'b0, wb_reg_write}, 1);
        chk("lh_rd", {27'b0, wb_rd_addr}, 7);
        chk("lh_m2r", {31'b0, wb_mem_to_reg}, 1);

        // LHU same access
        set_ex(1, 1, 0, 1, 0, 3'b101, 32'h0000_0102, 0, 0, 5'd7);
        run_access(2, 1, 32'h8001_1234);
        chk("lhu_stalls", stalls, 3);
        chk("lhu_data", wb_load_data, 32'h0000_8001);

        // LB 0x101, rvalid one cycle after same-cycle grant
        set_ex(1, 1, 0, 1, 0, 3'b000, 32'h0000_0101, 0, 0, 5'd3);
        run_access(0, 1, 32'h0000_F200);
        chk("lb_stalls", stalls, 1);
        chk("lb_data", wb_load_data, 32'hFFFF_FFF2);

        // LW 0x101 misaligned
        set_ex(1, 1, 0, 1, 0, 3'b010, 32'h0000_0101, 0, 0, 5'd4);
        run_access(0, 1, 32'h1111_1111);
        chk("mis_req", {31'b0, req0}, 0);
        chk("mis_stalls", stalls, 0);
        chk("mis_fault", {30'b0, wb_fault}, 2'b01);
        chk("mis_faddr", wb_fault_addr, 32'h0000_0101);
        chk("mis_rw", {31'b0, wb_reg_write}, 0);
        chk("mis_load_kept", wb_load_data, 32'hFFFF_FFF2);

        // LD on XLEN=32 and store with funct3[2]=1 are illegal widths
        set_ex(1, 1, 0, 1, 0, 3'b011, 32'h0000_0100, 0, 0, 5'd4);
        run_access(0, 1, 0);
        chk("ld_req", {31'b0, req0}, 0);
        chk("ld_fault", {30'b0, wb_fault}, 2'b11);
        set_ex(1, 0, 1, 0, 0, 3'b100, 32'h0000_0200, 32'h5, 0, 5'd0);
        run_access(0, 0, 0);
        chk("st4_req", {31'b0, req0}, 0);
        chk("st4_fault", {30'b0, wb_fault}, 2'b11);

        // Grant never arrives: timeout after 4 stall cycles
        set_ex(1, 1, 0, 1, 0, 3'b010, 32'h0000_0200, 0, 0, 5'd9);
        run_access(-1, 0, 0);
        chk("to_done", {31'b0, done}, 1);
        chk("to_stalls", stalls, 4);
        chk("to_fault", {30'b0, wb_fault}, 2'b10);
        chk("to_rw", {31'b0, wb_reg_write}, 0);
        chk("to_faddr", wb_fault_addr, 32'h0000_0200);
        chk("to_load_kept", wb_load_data, 32'hFFFF_FFF2);

        // Non-memory pass-through, link value then ALU value
        set_ex(1, 0, 0, 1, 1, 3'b000, 32'h0000_0055, 0, 32'h0000_1234, 5'd5);
        run_access(-1, 0, 0);
        chk("alu_pc_stalls", stalls, 0);
        chk("alu_pc_data", wb_rd_data, 32'h0000_1234);
        chk("alu_pc_fault", {30'b0, wb_fault}, 0);
        chk("alu_pc_load_kept", wb_load_data, 32'hFFFF_FFF2);
        set_ex(1, 0, 0, 1, 0, 3'b000, 32'h0000_0055, 0, 32'h0000_1234, 5'd5);
        run_access(-1, 0, 0);
        chk("alu_data", wb_rd_data, 32'h0000_0055);

        // Reset while waiting for rvalid; late rvalid must be dropped
        set_ex(1, 1, 0, 1, 0, 3'b010, 32'h0000_0300, 0, 0, 5'd6);
        dm_gnt = 1'b1;
        @(negedge clk);
        chk("rr_req", {31'b0, dm_req}, 1);
        @(posedge clk); #1;
        dm_gnt = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rr_req_in_rst", {31'b0, dm_req}, 0);
        chk("rr_stall_in_rst", {31'b0, mem_stall}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        set_ex(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 5'd0);
        dm_rvalid = 1'b1; dm_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("rr_idle_req", {31'b0, dm_req}, 0);
        @(posedge clk); #1;
        dm_rvalid = 1'b0;
        chk("rr_wb_valid", {31'b0, wb_valid}, 0);
        chk("rr_wb_rw", {31'b0, wb_reg_write}, 0);
        chk("rr_wb_load", wb_load_data, 0);
        chk("rr_wb_fault", {30'b0, wb_fault}, 0);

        set_ex(1, 1, 0, 1, 0, 3'b010, 32'h0000_0300, 0, 0, 5'd6);
        run_access(0, 1, 32'h1122_3344);
        chk("rr_lw_stalls", stalls, 1);
        chk("rr_lw_data", wb_load_data, 32'h1122_3344);
        chk("rr_lw_rw", {31'b0, wb_reg_write}, 1);

        // Back-to-back SW then LW, zero wait
        set_ex(1, 0, 1, 0, 0, 3'b010, 32'h0000_0010, 32'h5566_7788, 0, 5'd0);
        run_access(0, 0, 0);
        chk("b2b_sw_stalls", stalls, 0);
        chk("b2b_sw_rd", wb_rd_data, 32'h0000_0010);
        chk("b2b_sw_rw", {31'b0, wb_reg_write}, 0);
        set_ex(1, 1, 0, 1, 0, 3'b010, 32'h0000_0010, 0, 0, 5'd8);
        run_access(0, 1, 32'h5566_7788);
        chk("b2b_lw_stalls", stalls, 1);
        chk("b2b_lw_data", wb_load_data, 32'h5566_7788);
        chk("b2b_lw_rd", {27'b0, wb_rd_addr}, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
